// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants for the sprite pixel pipe.
// Holds entity codes, the facing-direction enum, sprite sheet bases,
// the 16-entry palette, per-entity body colours and the maze colour.
package sprite_pkg;

  // Entity codes after normalisation (anything above 6 folds to NONE)
  localparam logic [2:0] CODE_NONE   = 3'd0;
  localparam logic [2:0] CODE_PACMAN = 3'd1;
  localparam logic [2:0] CODE_MAZE   = 3'd2;
  localparam logic [2:0] CODE_BLINKY = 3'd3;
  localparam logic [2:0] CODE_PINKY  = 3'd4;
  localparam logic [2:0] CODE_INKY   = 3'd5;
  localparam logic [2:0] CODE_CLYDE  = 3'd6;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } dir_e;

  // Sheet layout: Pac-Man frames 0..2, ghosts pairs starting at 4
  localparam logic [3:0] SHEET_PACMAN_BASE = 4'd0;
  localparam logic [3:0] SHEET_GHOST_BASE  = 4'd4;

  // Phase used when animation is compiled out
  localparam logic [1:0] ANIM_PHASE_FIXED = 2'd2;

  // Shared palette; entries 0 (transparent) and 1 (body) are overridden
  localparam logic [23:0] PALETTE [16] = '{
    24'h000000, 24'h000000, 24'hFFFFFF, 24'h2121DE,
    24'hFFB897, 24'hDEDEFF, 24'hFF0000, 24'h00FF00,
    24'hFFB852, 24'hFFFF00, 24'h47B7AE, 24'hDE9751,
    24'hFFB8FF, 24'h00FFFF, 24'h2121FF, 24'h808080
  };

  localparam logic [23:0] PACMAN_RGB = 24'hFFFF00;
  localparam logic [23:0] BLINKY_RGB = 24'hFF0000;
  localparam logic [23:0] PINKY_RGB  = 24'hFFB8FF;
  localparam logic [23:0] INKY_RGB   = 24'h00FFFF;
  localparam logic [23:0] CLYDE_RGB  = 24'hFFB852;
  localparam logic [23:0] MAZE_RGB   = 24'h2121DE;

  // Fold out-of-range entity codes onto CODE_NONE
  function automatic logic [2:0] norm_code(input logic [6:0] code);
    return (code <= 7'd6) ? code[2:0] : CODE_NONE;
  endfunction

  // True for entities drawn from the sprite ROM
  function automatic logic is_sprite(input logic [2:0] code);
    return (code == CODE_PACMAN) ||
           ((code >= CODE_BLINKY) && (code <= CODE_CLYDE));
  endfunction

  // Body colour substituted for palette index 1
  function automatic logic [23:0] body_rgb(input logic [2:0] code);
    case (code)
      CODE_PACMAN: return PACMAN_RGB;
      CODE_BLINKY: return BLINKY_RGB;
      CODE_PINKY:  return PINKY_RGB;
      CODE_INKY:   return INKY_RGB;
      CODE_CLYDE:  return CLYDE_RGB;
      default:     return 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/sprite_palette.sv
// sprite_palette: combinational map from (entity code, palette index)
// to {opaque, rgb}. Index 0 is transparent, index 1 is the entity body.
module sprite_palette
  import sprite_pkg::*;
(
  input  logic [2:0]  code,
  input  logic [3:0]  pal_idx,
  output logic        opaque,
  output logic [23:0] rgb
);

  // Resolve the palette index to a colour
  always_comb begin
    opaque = 1'b0;
    rgb    = 24'h000000;
    if (pal_idx == 4'd1) begin
      opaque = 1'b1;
      rgb    = body_rgb(code);
    end else if (pal_idx != 4'd0) begin
      opaque = 1'b1;
      rgb    = PALETTE[pal_idx];
    end
  end

endmodule

// File: rtl/sprite_pixel_pipe.sv
// sprite_pixel_pipe: 3-cycle sprite fetch and colour pipeline.
// Cycle n: address formed, registered into rom_addr (visible n+1).
// Cycle n+2: rom_data meets delayed sideband; colour registered at n+3.
// Optional feature macro SPRITE_ANIM_EN builds the frame/phase counters;
// without it anim_phase is fixed at 2 and frame_sync is ignored.
module sprite_pixel_pipe
  import sprite_pkg::*;
#(
  parameter int SPRITE_SIZE = 16,
  parameter int FRAME_DIV   = 8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_sync,
  input  logic        pix_valid,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [6:0]  entity_code,
  input  logic [1:0]  entity_dir,
  input  logic [9:0]  entityX,
  input  logic [9:0]  entityY,
  output logic [11:0] rom_addr,
  input  logic [3:0]  rom_data,
  output logic        pix_out_valid,
  output logic        opaque,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);

  localparam logic signed [10:0] OFS_MAX = 11'(SPRITE_SIZE - 1);

  logic [1:0] anim_phase;

`ifdef SPRITE_ANIM_EN
  localparam logic [7:0] FRAME_LAST = 8'(FRAME_DIV - 1);

  logic [7:0] frame_cnt;

  // Count frame_sync pulses; step the animation phase on each wrap
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_cnt  <= 8'd0;
      anim_phase <= 2'd0;
    end else if (frame_sync) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt  <= 8'd0;
        anim_phase <= anim_phase + 2'd1;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end
`else
  logic unused_anim;
  assign anim_phase  = ANIM_PHASE_FIXED;
  assign unused_anim = ^{frame_sync, 8'(FRAME_DIV)};
`endif

  // ---- stage p0: offsets, orientation, sheet, address ----
  logic signed [10:0] u_p0, v_p0;
  logic               in_box_p0;
  logic [2:0]         code_p0;
  logic [3:0]         col_p0, row_p0, sheet_p0;
  logic [1:0]         ghost_idx_p0;
  logic [11:0]        addr_p0;

  // Local offsets, direction transform and sheet selection
  always_comb begin
    code_p0   = norm_code(entity_code);
    u_p0      = $signed({1'b0, DrawX}) - $signed({1'b0, entityX});
    v_p0      = $signed({1'b0, DrawY}) - $signed({1'b0, entityY});
    in_box_p0 = (u_p0 >= 11'sd0) && (u_p0 <= OFS_MAX) &&
                (v_p0 >= 11'sd0) && (v_p0 <= OFS_MAX);
    col_p0    = u_p0[3:0];
    row_p0    = v_p0[3:0];
    sheet_p0  = 4'd0;
    addr_p0   = 12'd0;
    ghost_idx_p0 = code_p0[1:0] - 2'd3;
    if (code_p0 == CODE_PACMAN) begin
      case (dir_e'(entity_dir))
        DIR_DOWN: begin col_p0 = v_p0[3:0];  row_p0 = u_p0[3:0]; end
        DIR_LEFT: begin col_p0 = ~u_p0[3:0]; row_p0 = v_p0[3:0]; end
        DIR_UP:   begin col_p0 = ~v_p0[3:0]; row_p0 = u_p0[3:0]; end
        default:  begin col_p0 = u_p0[3:0];  row_p0 = v_p0[3:0]; end
      endcase
      case (anim_phase)
        2'd0:    sheet_p0 = SHEET_PACMAN_BASE;
        2'd2:    sheet_p0 = SHEET_PACMAN_BASE + 4'd2;
        default: sheet_p0 = SHEET_PACMAN_BASE + 4'd1;
      endcase
    end else begin
      if (dir_e'(entity_dir) == DIR_LEFT) col_p0 = ~u_p0[3:0];
      sheet_p0 = SHEET_GHOST_BASE + {1'b0, ghost_idx_p0, 1'b0} +
                 {3'b000, anim_phase[0]};
    end
    if (is_sprite(code_p0) && in_box_p0)
      addr_p0 = {sheet_p0, row_p0, col_p0};
  end

  // ---- stage p1: registered ROM address and sideband ----
  logic [2:0] code_p1, code_p2;
  logic       in_box_p1, in_box_p2;
  logic       vld_p1, vld_p2;

  // Register the ROM address together with its sideband
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr  <= 12'd0;
      code_p1   <= CODE_NONE;
      in_box_p1 <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      rom_addr  <= addr_p0;
      code_p1   <= code_p0;
      in_box_p1 <= in_box_p0;
      vld_p1    <= pix_valid;
    end
  end

  // ---- stage p2: sideband delayed to meet rom_data ----
  // Delay sideband one more cycle while the ROM read is in flight
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      code_p2   <= CODE_NONE;
      in_box_p2 <= 1'b0;
      vld_p2    <= 1'b0;
    end else begin
      code_p2   <= code_p1;
      in_box_p2 <= in_box_p1;
      vld_p2    <= vld_p1;
    end
  end

  logic        pal_opaque;
  logic [23:0] pal_rgb;
  logic        opaque_p2;
  logic [23:0] rgb_p2;

  sprite_palette u_palette (
    .code    (code_p2),
    .pal_idx (rom_data),
    .opaque  (pal_opaque),
    .rgb     (pal_rgb)
  );

  // Pick maze, sprite or transparent colour for this pixel
  always_comb begin
    opaque_p2 = 1'b0;
    rgb_p2    = 24'h000000;
    if (vld_p2) begin
      if (code_p2 == CODE_MAZE) begin
        opaque_p2 = 1'b1;
        rgb_p2    = MAZE_RGB;
      end else if (is_sprite(code_p2) && in_box_p2) begin
        opaque_p2 = pal_opaque;
        rgb_p2    = pal_rgb;
      end
    end
  end

  // ---- stage p3: registered colour output ----
  // Register the final colour and valid
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_out_valid <= 1'b0;
      opaque        <= 1'b0;
      red           <= 8'd0;
      green         <= 8'd0;
      blue          <= 8'd0;
    end else begin
      pix_out_valid <= vld_p2;
      opaque        <= opaque_p2;
      {red, green, blue} <= rgb_p2;
    end
  end

endmodule

// File: doc/sprite_pixel_pipe.md
# sprite_pixel_pipe

Pipelined sprite pixel fetcher that sits directly downstream of the entity priority selector in the Pac-Man VGA renderer. Each cycle it takes the winning entity code, sprite origin and facing direction for the current DrawX/DrawY. It forms an address into the synchronous sprite ROM and maps the returned palette index to 24-bit RGB. It also owns the sprite animation phase counter, which advances on frame sync pulses.

## Interface
- SPRITE_SIZE, 16, sprite edge in pixels; power of two, fixed at 16 in this revision.
- FRAME_DIV, 8, number of frame_sync pulses per animation phase step; range 1..255.

- Clk  in  1  pixel clock
- Reset_n  in  1  asynchronous, active-low reset
- frame_sync  in  1  one-cycle pulse at vertical blank start
- pix_valid  in  1  DrawX/DrawY/entity inputs valid this cycle
- DrawX, DrawY  in  10 each  current pixel
- entity_code  in  7  0 none, 1 pacman, 2 maze, 3 blinky, 4 pinky, 5 inky, 6 clyde; 7..127 treated as 0
- entity_dir  in  2  0 right, 1 down, 2 left, 3 up
- entityX, entityY  in  10 each  sprite top-left corner
- rom_addr  out  12  registered; {sheet[3:0], row[3:0], col[3:0]}
- rom_data  in  4  palette index, valid one cycle after rom_addr
- pix_out_valid  out  1  rgb/opaque correspond to a valid input pixel
- opaque  out  1  pixel covers background
- red, green, blue  out  8 each  output colour

## Operation
- Local offsets use 11-bit signed arithmetic: u = DrawX − entityX and v = DrawY − entityY.
- in_box is asserted iff 0 ≤ u ≤ 15 and 0 ≤ v ≤ 15.
- Pac-Man (col, row) transform by direction:
  - dir 0: (u, v)
  - dir 1: (v, u)
  - dir 2: (15−u, v)
  - dir 3: (15−v, u)
- Ghosts use (15−u, v) for dir 2 and (u, v) for every other direction.
- Sheet selection:
  - Pac-Man: anim_phase 0→0, 1→1, 2→2, 3→1 (ping-pong).
  - Ghost: 4 + 2·(code−3) + anim_phase[0].
- rom_addr is 0 for codes 0, 2, invalid codes, and out-of-box pixels.
- Animation: frame_cnt counts frame_sync pulses 0..FRAME_DIV−1. On wrap, anim_phase (2 bits) increments mod 4.
- Colour stage, sprites, in_box:
  - rom_data 0: opaque = 0, rgb = 0.
  - rom_data 1: body colour.
    - Pac-Man FFFF00
    - blinky FF0000
    - pinky FFB8FF
    - inky 00FFFF
    - clyde FFB852
  - rom_data 2..15: palette constants.
- Colour stage, other cases:
  - Maze: opaque = 1, rgb = 2121DE.
  - None, or sprite out of box: opaque = 0, rgb = 0.
- pix_valid low: the pipeline still advances. The corresponding output has pix_out_valid = 0, opaque = 0 and rgb = 0.

## Timing
- Input in cycle n → rom_addr registered at n+1; ROM returns rom_data at n+2; opaque/rgb/pix_out_valid registered at n+3. Fixed latency of 3 with no stalls.
- Sideband (code, in_box, valid) is delayed alongside the address so it meets rom_data at n+2.
- anim_phase is sampled when the address is formed at cycle n. A frame_sync wrap in cycle n affects inputs from cycle n+1 onward.
- frame_sync arriving together with pix_valid is legal; the two are independent.
- Reset, asserted at any time including mid-stream:
  - All pipeline registers clear, so rom_addr = 0, pix_out_valid = 0, opaque = 0, rgb = 0.
  - frame_cnt = 0 and anim_phase = 0.
  - The first valid output appears 3 cycles after the first valid input following deassertion.

## Configuration
- SPRITE_ANIM_EN defined: frame_cnt and anim_phase operate as described.
- SPRITE_ANIM_EN undefined: the counters are not built and anim_phase is constant 2. Pac-Man always uses sheet 2 and ghosts always use their even sheet; frame_sync is ignored.

## Structure
- Package sprite_pkg holds:
  - entity code constants and direction enum
  - sheet base constants
  - the 16-entry palette array
  - ghost body colours and MAZE_RGB
- Sub-module sprite_palette: combinational map from (code, palette index) to {opaque, rgb}, instantiated in the colour stage.

## Test plan
- Reset mid-stream: drive Reset_n = 0 during valid traffic → all outputs 0 immediately; after release, anim_phase = 0 and the first pix_out_valid comes 3 cycles after the first pix_valid.
- Pac-Man, code 1, origin (100,50), dir 0, Draw (103,52), phase 0:
  - rom_addr = 35 at n+1.
  - Return rom_data = 1 at n+2 → rgb FFFF00, opaque 1 at n+3.
- Same pixel with dir 3: rom_addr = 61 (col 13, row 3). With dir 2: rom_addr = 44.
- Blinky, code 3, origin (200,200):
  - Draw (199,205) → rom_addr 0, opaque 0, rgb 0.
  - Draw (200,200) with rom_data 1 → rom_addr 1024, rgb FF0000.
  - Inky at the same pixel → rom_addr 2048, rgb 00FFFF.
- Animation, FRAME_DIV = 8, SPRITE_ANIM_EN defined:
  - 8 frame_sync pulses → Pac-Man sheet 1 (rom_addr 256+35).
  - 24 pulses → sheet 1 (phase 3).
  - 32 pulses → sheet 0.
- Maze and invalid codes:
  - Code 2 → rom_addr 0, rgb 2121DE, opaque 1.
  - Code 9 → opaque 0, rgb 0.
  - pix_valid = 0 → pix_out_valid 0 at n+3.
